alu_op_sequencer: RTL

//  Upstream feeder for the serial 8-bit ALU (add/sub/Booth mul/div).
//  - Accepts one operation per valid/ready request and launches the ALU with a 1-cycle Begin pulse.
//  - Serialises the A, Q and M operand words onto the ALU inbus on a fixed, parameterised schedule.
//  - Captures the result words from the ALU outbus and returns them through a valid/ready response port.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_sched.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the serial-ALU operand sequencer: op codes, FSM states,
// inbus source select and the latched request word.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        CAPT   = 3'd3,
        RESP   = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_Q    = 2'd2,
        SEL_M    = 2'd3
    } inbus_sel_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] q;
        logic [7:0] m;
    } seq_req_t;

    // mul and div return two result words; add and sub only one
    function automatic logic is_muldiv(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_seq_sched.sv
// Combinational operand/capture schedule: maps the RUN counter and op onto
// the inbus source select and the high-word capture strobe.
module alu_seq_sched
    import alu_seq_pkg::*;
#(
    parameter int PH_A   = 1,
    parameter int PH_Q   = 2,
    parameter int PH_M   = 3,
    parameter int LAT_AS = 12,
    parameter int LAT_MD = 40
) (
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output inbus_sel_e       sel,
    output logic             cap_hi
);

    localparam logic [CNT_W-1:0] C_A  = CNT_W'(PH_A);
    localparam logic [CNT_W-1:0] C_Q  = CNT_W'(PH_Q);
    localparam logic [CNT_W-1:0] C_M  = CNT_W'(PH_M);
    localparam logic [CNT_W-1:0] C_M1 = CNT_W'(PH_M + 1);
    localparam logic [CNT_W-1:0] C_AS = CNT_W'(LAT_AS);
    localparam logic [CNT_W-1:0] C_MD = CNT_W'(LAT_MD);

    always_comb begin
        sel = SEL_NONE;
        if (run) begin
            if (cnt >= C_A && cnt < C_Q)
                sel = SEL_A;
            else if (cnt >= C_Q && cnt < C_M)
                sel = SEL_Q;
            else if (cnt >= C_M && cnt <= C_M1)
                sel = SEL_M;
        end
    end

    assign cap_hi = run && (cnt == (is_muldiv(op) ? C_MD : C_AS));

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the serial 8-bit ALU: launches one op,
// streams A/Q/M onto the inbus, captures the result words off the outbus.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PH_A   = 1,
    parameter int PH_Q   = 2,
    parameter int PH_M   = 3,
    parameter int LAT_AS = 12,
    parameter int LAT_MD = 40
) (
    input  logic       CLk,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_q,
    input  logic [7:0] req_m,
    output logic       alu_begin,
    output logic [1:0] alu_op,
    output logic [7:0] alu_inbus,
    input  logic [7:0] alu_outbus,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic       busy
);

    if (!(PH_A < PH_Q && PH_Q < PH_M && PH_M + 1 < LAT_AS &&
          LAT_AS <= LAT_MD && LAT_MD + 1 < 64)) begin : g_bad_params
        $error("alu_op_sequencer: illegal schedule parameters");
    end

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    seq_req_t         req_r;
    inbus_sel_e       sel;
    logic             cap_hi;

    alu_seq_sched #(
        .PH_A  (PH_A),
        .PH_Q  (PH_Q),
        .PH_M  (PH_M),
        .LAT_AS(LAT_AS),
        .LAT_MD(LAT_MD)
    ) u_sched (
        .run   (state == RUN),
        .cnt   (cnt),
        .op    (req_r.op),
        .sel   (sel),
        .cap_hi(cap_hi)
    );

    assign alu_op = req_r.op;

    // inbus is a pure decode of registered state, so it only moves on clock edges
    always_comb begin
        case (sel)
            SEL_A:   alu_inbus = req_r.a;
            SEL_Q:   alu_inbus = req_r.q;
            SEL_M:   alu_inbus = req_r.m;
            default: alu_inbus = '0;
        endcase
    end

    always_ff @(posedge CLk) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            req_r     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            alu_begin <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hi    <= '0;
            rsp_lo    <= '0;
        end else begin
            alu_begin <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_r     <= '{op: req_op, a: req_a, q: req_q, m: req_m};
                        state     <= LAUNCH;
                        alu_begin <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cap_hi) begin
                        rsp_hi <= alu_outbus;
                        if (is_muldiv(req_r.op)) begin
                            state <= CAPT;
                        end else begin
                            rsp_lo    <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                CAPT: begin
                    // low word follows the high word by exactly one cycle
                    cnt       <= cnt + CNT_W'(1);
                    rsp_lo    <= alu_outbus;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
